// File: rtl/tlc_junction_arbiter.sv
// -----------------------------------------------------------------------------
// tlc_junction_arbiter
//
// Right-of-way arbiter for a two-approach junction. It sits between the
// per-approach light units (north-south and east-west) and the board wrapper.
// Car-sensor requests are served round-robin. Each grant has a minimum green
// time and an anti-starvation maximum green time, and an all-red clearance
// interval separates consecutive grants. A grant is issued only while both
// light units report red.
//
// Optional feature (macro TLC_PED_WALK_EN): a pedestrian request is latched.
// Once the junction is idle and both approaches are red, the latched request
// takes priority and runs a walk phase of T_WALK ticks, followed by clearance.
// A pending pedestrian request also counts as a competitor, so it can shorten
// the current green. With the macro undefined, the walk ports do not exist
// and the WALK phase cannot be reached.
//
// Ports:
//   clk        clock
//   rst        synchronous, active-high reset
//   i_tick     1-cycle time-base strobe; every timer advances only on it
//   i_req_ns   NS vehicle sensor (level)
//   i_req_ew   EW vehicle sensor (level)
//   i_safe_ns  NS light unit is red / settled
//   i_safe_ew  EW light unit is red / settled
//   i_ped_req  pedestrian request, level or pulse (TLC_PED_WALK_EN only)
//   o_walk     walk indication (TLC_PED_WALK_EN only)
//   o_on_ns    green request to the NS light unit
//   o_on_ew    green request to the EW light unit
//   o_phase    current phase: IDLE=0 GNT_NS=1 REL_NS=2 CLEAR=3
//              GNT_EW=4 REL_EW=5 WALK=6
//   o_last_ns  1 when NS holds the most recent grant (round-robin pointer)
// -----------------------------------------------------------------------------
module tlc_junction_arbiter #(
    parameter int unsigned   CW          = 8,
    parameter logic [CW-1:0] T_MIN_GREEN = CW'(10),
    parameter logic [CW-1:0] T_MAX_GREEN = CW'(40),
    parameter logic [CW-1:0] T_CLEAR     = CW'(3),
    parameter logic [CW-1:0] T_WALK      = CW'(12)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tick,
    input  logic       i_req_ns,
    input  logic       i_req_ew,
    input  logic       i_safe_ns,
    input  logic       i_safe_ew,
`ifdef TLC_PED_WALK_EN
    input  logic       i_ped_req,
    output logic       o_walk,
`endif
    output logic       o_on_ns,
    output logic       o_on_ew,
    output logic [2:0] o_phase,
    output logic       o_last_ns
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GNT_NS = 3'd1,
        ST_REL_NS = 3'd2,
        ST_CLEAR  = 3'd3,
        ST_GNT_EW = 3'd4,
        ST_REL_EW = 3'd5,
        ST_WALK   = 3'd6
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_on_ns;
    logic          r_on_ew;
    logic          r_last_ns;

    logic [CW-1:0] w_cnt_next;
    logic          w_both_safe;
    logic          w_ped_pend;
    logic          w_ns_yield;
    logic          w_ew_yield;

    // The phase counter saturates at all-ones, so a green held for a very
    // long time with no competitor never wraps back below the thresholds.
    assign w_cnt_next  = (i_tick && (r_cnt != '1)) ? r_cnt + CW'(1) : r_cnt;
    assign w_both_safe = i_safe_ns & i_safe_ew;

`ifdef TLC_PED_WALK_EN
    logic r_ped_pend;
    logic r_walk;
    logic w_walk_done;

    assign w_walk_done = (r_state == ST_WALK) && (r_cnt >= T_WALK);

    // A new request during the final walk cycle is kept, not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ped_pend <= 1'b0;
        end else begin
            r_ped_pend <= (r_ped_pend & ~w_walk_done) | i_ped_req;
        end
    end

    assign w_ped_pend = r_ped_pend;
    assign o_walk     = r_walk;
`else
    assign w_ped_pend = 1'b0;
`endif

    // The holder yields only while someone else is waiting: after the
    // minimum green if its own sensor has gone quiet, otherwise at the
    // maximum green.
    assign w_ns_yield = (i_req_ew | w_ped_pend) &
                        ((r_cnt >= T_MAX_GREEN) | ((r_cnt >= T_MIN_GREEN) & ~i_req_ns));
    assign w_ew_yield = (i_req_ns | w_ped_pend) &
                        ((r_cnt >= T_MAX_GREEN) | ((r_cnt >= T_MIN_GREEN) & ~i_req_ew));

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register in this block reads the pre-edge values of its neighbours,
    // whatever the statement order.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge (synchronous), so it sits
        // inside the clocked branch and not in the sensitivity list.
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_on_ns   <= 1'b0;
            r_on_ew   <= 1'b0;
            r_last_ns <= 1'b0;
`ifdef TLC_PED_WALK_EN
            r_walk    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_both_safe) begin
                        if (w_ped_pend) begin
                            r_state <= ST_WALK;
                            r_cnt   <= '0;
`ifdef TLC_PED_WALK_EN
                            r_walk  <= 1'b1;
`endif
                        end else if (i_req_ns && (!i_req_ew || !r_last_ns)) begin
                            // On a tie, NS wins only if EW had the last grant.
                            r_state   <= ST_GNT_NS;
                            r_cnt     <= '0;
                            r_on_ns   <= 1'b1;
                            r_last_ns <= 1'b1;
                        end else if (i_req_ew) begin
                            r_state   <= ST_GNT_EW;
                            r_cnt     <= '0;
                            r_on_ew   <= 1'b1;
                            r_last_ns <= 1'b0;
                        end
                    end
                end

                ST_GNT_NS: begin
                    if (w_ns_yield) begin
                        r_state <= ST_REL_NS;
                        r_on_ns <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end

                ST_GNT_EW: begin
                    if (w_ew_yield) begin
                        r_state <= ST_REL_EW;
                        r_on_ew <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end

                // The light unit runs its own amber sequence. There is no
                // timeout: the junction stays all-red until the unit reports safe.
                ST_REL_NS: begin
                    if (i_safe_ns) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                    end
                end

                ST_REL_EW: begin
                    if (i_safe_ew) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                    end
                end

                ST_CLEAR: begin
                    if (r_cnt >= T_CLEAR) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end

                ST_WALK: begin
                    if (r_cnt >= T_WALK) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
`ifdef TLC_PED_WALK_EN
                        r_walk  <= 1'b0;
`endif
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_on_ns <= 1'b0;
                    r_on_ew <= 1'b0;
                end
            endcase
        end
    end

    assign o_on_ns   = r_on_ns;
    assign o_on_ew   = r_on_ew;
    assign o_phase   = r_state;
    assign o_last_ns = r_last_ns;

endmodule

// File: tb/tb_tlc_junction_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tlc_junction_arbiter
//
// Directed bench for tlc_junction_arbiter. An environment process produces a
// tick every TICK_DIV cycles and plays the two light units: each unit drops
// "safe" while its approach is green, and raises it again 4 ticks after the
// green request falls. A behavioural model tracks who owns the junction and
// for how many ticks, and every cycle the DUT outputs are compared against it.
// Hand-computed tick counts (green lengths, gaps, walk length) pin the model.
// -----------------------------------------------------------------------------
module tb_tlc_junction_arbiter;

    localparam int T_MIN    = 10;
    localparam int T_MAX    = 40;
    localparam int T_CLR    = 3;
    localparam int T_WLK    = 12;
    localparam int TICK_DIV = 4;
    localparam int SAFE_DLY = 4;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       tick    = 1'b0;
    logic       req_ns  = 1'b0;
    logic       req_ew  = 1'b0;
    logic       safe_ns = 1'b1;
    logic       safe_ew = 1'b1;
    logic       on_ns;
    logic       on_ew;
    logic [2:0] phase;
    logic       last_ns;
`ifdef TLC_PED_WALK_EN
    logic       ped_req = 1'b0;
    logic       walk;
`endif

    int n_vec      = 0;
    int n_err      = 0;
    int tick_count = 0;
    int div_cnt    = 0;
    int wait_ns    = 0;
    int wait_ew    = 0;
    bit hold_ns    = 1'b0;

    tlc_junction_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .i_tick    (tick),
        .i_req_ns  (req_ns),
        .i_req_ew  (req_ew),
        .i_safe_ns (safe_ns),
        .i_safe_ew (safe_ew),
`ifdef TLC_PED_WALK_EN
        .i_ped_req (ped_req),
        .o_walk    (walk),
`endif
        .o_on_ns   (on_ns),
        .o_on_ew   (on_ew),
        .o_phase   (phase),
        .o_last_ns (last_ns)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Environment: the tick strobe and the two light units. It drives 2 time
    // units after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            tick    = (div_cnt == 0);
            div_cnt = (div_cnt + 1) % TICK_DIV;
            if (tick) tick_count++;
            if (on_ns === 1'b1) begin
                safe_ns = 1'b0;
                wait_ns = 0;
            end else if (!safe_ns && !hold_ns) begin
                if (tick) wait_ns++;
                if (wait_ns >= SAFE_DLY) safe_ns = 1'b1;
            end
            if (on_ew === 1'b1) begin
                safe_ew = 1'b0;
                wait_ew = 0;
            end else if (!safe_ew) begin
                if (tick) wait_ew++;
                if (wait_ew >= SAFE_DLY) safe_ew = 1'b1;
            end
        end
    end

    // Behavioural model. The junction has an owner (0 none, 1 NS, 2 EW), and
    // an owner may be releasing. Clearance and walk are timed intervals.
    int m_owner   = 0;
    int m_t       = 0;
    bit m_rel     = 1'b0;
    bit m_clr     = 1'b0;
    bit m_walk    = 1'b0;
    bit m_last_ns = 1'b0;
    bit m_ped     = 1'b0;
    bit m_valid   = 1'b0;

    function automatic logic [2:0] m_phase();
        if (m_walk)        return 3'd6;
        if (m_clr)         return 3'd3;
        if (m_owner == 1)  return m_rel ? 3'd2 : 3'd1;
        if (m_owner == 2)  return m_rel ? 3'd5 : 3'd4;
        return 3'd0;
    endfunction

    always @(posedge clk) begin : model
        bit mine, other, ped_in, ped_done;
`ifdef TLC_PED_WALK_EN
        ped_in = ped_req;
`else
        ped_in = 1'b0;
`endif
        ped_done = 1'b0;
        if (rst) begin
            m_owner = 0; m_t = 0; m_rel = 0; m_clr = 0; m_walk = 0;
            m_last_ns = 0; m_ped = 0; m_valid = 1;
        end else if (m_valid) begin
            if (m_walk) begin
                if (m_t >= T_WLK) begin
                    m_walk = 0; m_clr = 1; m_t = 0; ped_done = 1;
                end else if (tick) m_t++;
            end else if (m_clr) begin
                if (m_t >= T_CLR) m_clr = 0;
                else if (tick) m_t++;
            end else if (m_owner != 0) begin
                if (m_rel) begin
                    if ((m_owner == 1) ? safe_ns : safe_ew) begin
                        m_owner = 0; m_rel = 0; m_clr = 1; m_t = 0;
                    end
                end else begin
                    mine  = (m_owner == 1) ? req_ns : req_ew;
                    other = ((m_owner == 1) ? req_ew : req_ns) | m_ped;
                    if (other && (m_t >= T_MAX || (m_t >= T_MIN && !mine))) m_rel = 1;
                    else if (tick) m_t++;
                end
            end else if (safe_ns && safe_ew) begin
                if (m_ped) begin
                    m_walk = 1; m_t = 0;
                end else if (req_ns && (!req_ew || !m_last_ns)) begin
                    m_owner = 1; m_t = 0; m_last_ns = 1;
                end else if (req_ew) begin
                    m_owner = 2; m_t = 0; m_last_ns = 0;
                end
            end
            m_ped = (m_ped && !ped_done) || ped_in;
        end
    end

    // One compare process: every cycle, on the falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("on_ns", on_ns, m_owner == 1 && !m_rel);
            check("on_ew", on_ew, m_owner == 2 && !m_rel);
            check("phase", phase, m_phase());
            check("last_ns", last_ns, m_last_ns);
            check("on_exclusive", on_ns & on_ew, 1'b0);
`ifdef TLC_PED_WALK_EN
            check("walk", walk, m_walk);
`endif
        end
    end

    function automatic logic sig(input int sel);
        case (sel)
            0: return on_ns;
            1: return on_ew;
            2: return phase == 3'd3;
`ifdef TLC_PED_WALK_EN
            3: return walk;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // Waits on falling edges for a signal to reach val. tc_before is the tick
    // count at the last edge before the change, and tc_at is the count at the
    // edge where it is first seen. A wait that runs out of cycles fails.
    task automatic wait_sig(input int sel, input logic val, input int max_cyc, input string name,
                            output int tc_before, output int tc_at);
        int c;
        c = 0;
        tc_before = tick_count;
        @(negedge clk);
        while (sig(sel) !== val && c < max_cyc) begin
            tc_before = tick_count;
            @(negedge clk);
            c++;
        end
        tc_at = tick_count;
        check(name, sig(sel), val);
    endtask

    initial begin
        int s, e, g0, c3, dummy, c;

        // Reset, then 50 idle ticks
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_phase", phase, 3'd0);
        check("rst_on_ns", on_ns, 1'b0);
        check("rst_on_ew", on_ew, 1'b0);
        check("rst_last_ns", last_ns, 1'b0);
        repeat (50 * TICK_DIV) @(negedge clk);
        check("idle_phase", phase, 3'd0);
        check("idle_on_ns", on_ns, 1'b0);
        check("idle_on_ew", on_ew, 1'b0);

        // Single NS request: granted on the next edge, then held with no competitor
        req_ns = 1'b1;
        @(negedge clk);
        check("lat_on_ns", on_ns, 1'b1);
        check("lat_phase", phase, 3'd1);
        check("lat_last_ns", last_ns, 1'b1);
        repeat (100 * TICK_DIV) @(negedge clk);
        check("hold_on_ns", on_ns, 1'b1);
        check("hold_phase", phase, 3'd1);

        // Both requesting: NS has gone past max green, so it yields at once
        req_ew = 1'b1;
        wait_sig(0, 1'b0, 4, "ns_yield_now", dummy, e);
        wait_sig(1, 1'b1, 400, "ew_grant1", s, dummy);
        wait_sig(1, 1'b0, 400, "ew_release1", dummy, e);
        check("green_ew1_len", 16'(e - s), 16'(T_MAX));
        g0 = e;
        wait_sig(0, 1'b1, 400, "ns_grant2", s, dummy);
        check("gap_ew_ns", 16'(s - g0), 16'(SAFE_DLY + T_CLR));
        wait_sig(0, 1'b0, 400, "ns_release2", dummy, e);
        check("green_ns2_len", 16'(e - s), 16'(T_MAX));
        g0 = e;
        wait_sig(1, 1'b1, 400, "ew_grant3", s, dummy);
        check("gap_ns_ew", 16'(s - g0), 16'(SAFE_DLY + T_CLR));
        wait_sig(1, 1'b0, 400, "ew_release3", dummy, e);
        check("green_ew3_len", 16'(e - s), 16'(T_MAX));
        g0 = e;
        wait_sig(0, 1'b1, 400, "ns_grant4", s, dummy);
        check("gap_ew_ns2", 16'(s - g0), 16'(SAFE_DLY + T_CLR));

        // Minimum green: EW drops out, then at tick 5 NS goes quiet and EW returns
        req_ew = 1'b0;
        c = 0;
        while (tick_count - s < 5 && c < 200) begin
            @(negedge clk);
            c++;
        end
        req_ns = 1'b0;
        req_ew = 1'b1;
        wait_sig(0, 1'b0, 400, "ns_min_release", dummy, e);
        check("min_green_len", 16'(e - s), 16'(T_MIN));

        // NS light unit stuck red-pending after release: junction waits in REL_NS
        wait_sig(1, 1'b1, 400, "ew_grant5", s, dummy);
        req_ns = 1'b1;
        req_ew = 1'b0;
        wait_sig(0, 1'b1, 400, "ns_grant6", s, dummy);
        hold_ns = 1'b1;
        req_ns  = 1'b0;
        req_ew  = 1'b1;
        wait_sig(0, 1'b0, 400, "ns_release6", dummy, dummy);
        repeat (20 * TICK_DIV) @(negedge clk);
        check("stuck_phase", phase, 3'd2);
        check("stuck_on_ew", on_ew, 1'b0);
        hold_ns = 1'b0;
        wait_sig(2, 1'b1, 200, "clear_entry", dummy, c3);
        wait_sig(1, 1'b1, 200, "ew_after_clear", s, dummy);
        check("clear_len", 16'(s - c3), 16'(T_CLR));

`ifdef TLC_PED_WALK_EN
        // Pedestrian pulse at tick 12 of an uncontested EW green
        req_ew = 1'b0;
        c = 0;
        while (tick_count - s < 12 && c < 200) begin
            @(negedge clk);
            c++;
        end
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        wait_sig(1, 1'b0, 200, "ew_ped_release", dummy, dummy);
        wait_sig(3, 1'b1, 200, "walk_start", s, dummy);
        check("walk_on_ns", on_ns, 1'b0);
        check("walk_on_ew", on_ew, 1'b0);
        check("walk_phase", phase, 3'd6);
        req_ns = 1'b1;
        wait_sig(3, 1'b0, 200, "walk_end", dummy, e);
        check("walk_len", 16'(e - s), 16'(T_WLK));
        wait_sig(0, 1'b1, 200, "ns_after_walk", dummy, dummy);
        check("after_walk_last_ns", last_ns, 1'b1);
`endif

        // Reset in the middle of a green drops it on the next edge
        repeat (8) @(negedge clk);
        check("pre_rst_busy", on_ns | on_ew, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_on_ns", on_ns, 1'b0);
        check("mid_rst_on_ew", on_ew, 1'b0);
        check("mid_rst_phase", phase, 3'd0);
        check("mid_rst_last_ns", last_ns, 1'b0);
        rst    = 1'b0;
        req_ns = 1'b0;
        req_ew = 1'b0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tlc_junction_arbiter.md
Name: tlc_junction_arbiter

Overview:
Arbitrates right-of-way at a two-approach junction between the north-south (NS) and east-west (EW) light controllers. It drives each light controller's level "on" request and watches each controller's "safe" (showing red) return. Car-sensor requests are served round-robin, with a minimum green time, a maximum green time (anti-starvation) and an all-red clearance interval between phases. It sits above the per-approach light units and below the top-level board wrapper.

Parameters:
CW, 8, width of the phase tick counter
T_MIN_GREEN, 8'd10, minimum ticks an approach holds "on" once granted
T_MAX_GREEN, 8'd40, ticks after which "on" is withdrawn if the other approach is requesting
T_CLEAR, 8'd3, all-red ticks between losing and gaining approach
T_WALK, 8'd12, walk ticks (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
tick  in  1  1-cycle time-base strobe; all timers count only on tick
req_ns  in  1  NS vehicle sensor, level
req_ew  in  1  EW vehicle sensor, level
safe_ns  in  1  NS light unit reports red/settled
safe_ew  in  1  EW light unit reports red/settled
on_ns  out  1  green request to NS light unit
on_ew  out  1  green request to EW light unit
phase  out  3  current FSM state encoding (debug/display)
last_ns  out  1  1 if NS was the most recently granted approach (round-robin pointer)

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, on_ns=0, on_ew=0, cnt=0, last_ns=0 (EW treated as last, so NS wins the first tie). rst mid-operation drops both "on" signals in the next cycle, regardless of state.
- Invariant: on_ns & on_ew is never 1. A grant is asserted only when both safe_ns=1 and safe_ew=1.
- States and encoding: IDLE=0, GNT_NS=1, REL_NS=2, CLEAR=3, GNT_EW=4, REL_EW=5, WALK=6 (WALK only with the optional feature).
- IDLE: wait until both safe_* are 1 and at least one request is pending.
  - Both requesting: grant the approach opposite last_ns.
  - Single request: grant that approach.
  - Entering GNT_x: cnt<=0, on_x<=1 in the same edge, last_ns updated (1 for NS, 0 for EW).
- GNT_x: cnt increments on tick, saturating at all-ones. Leave to REL_x when either:
  - cnt>=T_MIN_GREEN and the other approach is requesting and req_x=0, or
  - cnt>=T_MAX_GREEN and the other approach is requesting.
  - If the other approach is not requesting, hold GNT_x indefinitely.
- REL_x: on_x=0. Wait for safe_x=1 (the yellow sequence runs in the light unit), then go to CLEAR with cnt<=0. No timeout.
- CLEAR: both on_* are 0. Count T_CLEAR ticks, then go to IDLE.
- Simultaneous events: a request arriving on the same cycle as a CLEAR->IDLE transition is evaluated in IDLE on the next cycle. A tick coinciding with a state entry is not counted.
- safe_x dropping while in IDLE or CLEAR (fault) blocks any grant until both safe_* return to 1; no error output.
- Output latency: on_* are registered and change the cycle after the decision edge condition is sampled.

Optional Feature:
Macro: TLC_PED_WALK_EN
- Defined: adds input ped_req (1b, level or pulse) and output walk (1b).
  - A ped_req pulse is latched into ped_pend.
  - In IDLE, ped_pend has highest priority once both safe_*=1: enter WALK, walk=1 for T_WALK ticks, clear ped_pend, then go to CLEAR.
  - ped_pend also shortens GNT_x: it counts as "other approach requesting".
  - walk resets to 0.
- Undefined: no ped_req/walk ports; WALK state is unreachable; phase never equals 6.

Test Plan:
- Reset with req_ns=req_ew=0, safe_*=1, 50 ticks -> on_ns=on_ew=0, phase=0 throughout.
- req_ns=1 only, safe_*=1 -> on_ns=1 one cycle after the IDLE evaluation. on_ns holds for 100 ticks (no competitor); phase=1, last_ns=1.
- req_ns=req_ew=1 held, safe_x returns 1 four ticks after on_x falls -> alternation NS, EW, NS… Each green lasts exactly 40 ticks (T_MAX_GREEN). Each gap is 4+3 ticks, with both on_*=0 during the gap.
- During GNT_NS, req_ns drops and req_ew rises at tick 5 -> release occurs at tick 10 (T_MIN_GREEN), not before.
- Hold safe_ns=0 after release -> FSM stays in REL_NS (phase=2) and on_ew never asserts. Raise safe_ns -> CLEAR for 3 ticks, then on_ew=1.
- With TLC_PED_WALK_EN: pulse ped_req during GNT_EW at tick 12 -> release, CLEAR, IDLE, then walk=1 for 12 ticks with on_*=0. Then CLEAR, followed by the grant for the pending vehicle request.
